// File: rtl/v_instr_dispatch_queue.sv
// In-order dispatch queue for vector instructions and their scalar operand, core -> vector coprocessor.
// Registered first-word-fall-through head; single-cycle flush; synchronous active-high reset.
module v_instr_dispatch_queue #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned INSTR_W = 32,
   parameter int unsigned XLEN    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   input  logic [INSTR_W-1:0]       in_instr,
   input  logic [XLEN-1:0]          in_xreg,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [INSTR_W-1:0]       out_instr,
   output logic [XLEN-1:0]          out_xreg,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned EW = INSTR_W + XLEN;

   logic [EW-1:0] mem_q [DEPTH];
   logic [EW-1:0] mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          out_valid_q, out_valid_d;
   logic [EW-1:0] head_q, head_d;
   logic          push, pop;

   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign in_ready  = !full;
   assign count     = count_q;
   assign out_valid = out_valid_q;
   assign out_instr = head_q[EW-1:XLEN];
   assign out_xreg  = head_q[XLEN-1:0];

   assign push = in_valid & in_ready;
   assign pop  = out_valid_q & out_ready;

   always_comb begin
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      out_valid_d = out_valid_q;
      head_d      = head_q;
      if (flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         out_valid_d = 1'b0;
         head_d      = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = {in_instr, in_xreg};
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (pop)
            rd_ptr_d = rd_ptr_q + PW'(1);
         count_d     = count_q + CW'(push) - CW'(pop);
         out_valid_d = (count_d != '0);
         // The new head is still being written this edge when nothing else remains queued.
         if (count_d == '0)
            head_d = '0;
         else if ((count_q - CW'(pop)) == '0)
            head_d = {in_instr, in_xreg};
         else
            head_d = mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         head_q      <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         head_q      <= head_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_v_instr_dispatch_queue.sv
// Bench for v_instr_dispatch_queue: directed vector table, then random traffic against a queue model.
module tb_v_instr_dispatch_queue;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [31:0] in_instr, in_xreg;
   logic        in_ready, out_valid, empty, full;
   logic [31:0] out_instr, out_xreg;
   logic [2:0]  count;

   int unsigned checks = 0;
   int unsigned errors = 0;

   v_instr_dispatch_queue #(.DEPTH(DEPTH), .INSTR_W(32), .XLEN(32)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_instr(in_instr), .in_xreg(in_xreg), .in_ready(in_ready),
      .out_valid(out_valid), .out_instr(out_instr), .out_xreg(out_xreg), .out_ready(out_ready),
      .count(count), .empty(empty), .full(full)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, flush, iv, ordy;
      logic [31:0] instr, xreg;
      logic        ev;
      logic [31:0] ei, ex;
      int unsigned ec;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic f, input logic iv, input logic ordy,
                      input logic [31:0] instr, input logic [31:0] xreg,
                      input logic ev, input logic [31:0] ei, input logic [31:0] ex,
                      input int unsigned ec);
      vec_t v;
      v.rst = r; v.flush = f; v.iv = iv; v.ordy = ordy; v.instr = instr; v.xreg = xreg;
      v.ev = ev; v.ei = ei; v.ex = ex; v.ec = ec;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic f, input logic iv, input logic ordy,
                        input logic [31:0] instr, input logic [31:0] xreg);
      rst = r; flush = f; in_valid = iv; out_ready = ordy; in_instr = instr; in_xreg = xreg;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic ev, input logic [31:0] ei,
                            input logic [31:0] ex, input int unsigned ec);
      chk({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
      chk({tag, ".out_instr"}, 64'(out_instr), 64'(ei));
      chk({tag, ".out_xreg"},  64'(out_xreg),  64'(ex));
      chk({tag, ".count"},     64'(count),     64'(ec));
      chk({tag, ".full"},      64'(full),      64'(ec == DEPTH));
      chk({tag, ".empty"},     64'(empty),     64'(ec == 0));
      chk({tag, ".in_ready"},  64'(in_ready),  64'(ec != DEPTH));
   endtask

   // Reference model: a plain queue of {instr, xreg}.
   logic [63:0] model[$];

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0; in_xreg = '0;

      // Reset and idle
      add(1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);
      add(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);
      // Single push, one-cycle latency
      add(0, 0, 1, 0, 32'h0000_0057, 32'h11, 1, 32'h0000_0057, 32'h11, 1);
      // Fill to full, fifth push ignored
      add(0, 0, 1, 0, 32'hA1, 32'h1, 1, 32'h57, 32'h11, 2);
      add(0, 0, 1, 0, 32'hA2, 32'h2, 1, 32'h57, 32'h11, 3);
      add(0, 0, 1, 0, 32'hA3, 32'h3, 1, 32'h57, 32'h11, 4);
      add(0, 0, 1, 0, 32'hA4, 32'h4, 1, 32'h57, 32'h11, 4);
      // Drain in order
      add(0, 0, 0, 1, 32'h0, 32'h0, 1, 32'hA1, 32'h1, 3);
      add(0, 0, 0, 1, 32'h0, 32'h0, 1, 32'hA2, 32'h2, 2);
      add(0, 0, 0, 1, 32'h0, 32'h0, 1, 32'hA3, 32'h3, 1);
      add(0, 0, 0, 1, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);
      // Steady count=2 with push+pop every cycle across pointer wrap
      add(0, 0, 1, 0, 32'hB0, 32'h50, 1, 32'hB0, 32'h50, 1);
      add(0, 0, 1, 0, 32'hB1, 32'h51, 1, 32'hB0, 32'h50, 2);
      for (int i = 0; i < 10; i++) begin
         if (i == 0)
            add(0, 0, 1, 1, 32'hC0, 32'h60, 1, 32'hB1, 32'h51, 2);
         else
            add(0, 0, 1, 1, 32'hC0 + 32'(i), 32'h60 + 32'(i), 1,
                32'hC0 + 32'(i - 1), 32'h60 + 32'(i - 1), 2);
      end
      // Flush with a simultaneous push: pushed word dropped
      add(0, 0, 1, 0, 32'hD0, 32'h70, 1, 32'hC8, 32'h68, 3);
      add(0, 1, 1, 0, 32'hD1, 32'h71, 0, 32'h0, 32'h0, 0);
      add(0, 0, 0, 1, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);
      // Reset mid-operation, then normal push
      add(0, 0, 1, 0, 32'hE0, 32'h80, 1, 32'hE0, 32'h80, 1);
      add(0, 0, 1, 0, 32'hE1, 32'h81, 1, 32'hE0, 32'h80, 2);
      add(1, 0, 1, 1, 32'hE2, 32'h82, 0, 32'h0, 32'h0, 0);
      add(0, 0, 1, 0, 32'h0000_0057, 32'h11, 1, 32'h0000_0057, 32'h11, 1);

      foreach (vecs[k]) begin
         drive(vecs[k].rst, vecs[k].flush, vecs[k].iv, vecs[k].ordy, vecs[k].instr, vecs[k].xreg);
         check_all($sformatf("vec%0d", k), vecs[k].ev, vecs[k].ei, vecs[k].ex, vecs[k].ec);
      end

      // Random traffic against the queue model
      drive(1, 0, 0, 0, 32'h0, 32'h0);
      model.delete();
      for (int n = 0; n < 600; n++) begin
         logic r, f, iv, ordy, do_push, do_pop;
         logic [31:0] ri, rx;
         r    = ($urandom_range(99) == 0);
         f    = ($urandom_range(39) == 0);
         iv   = ($urandom_range(99) < 60);
         ordy = ($urandom_range(99) < 50);
         ri   = $urandom;
         rx   = $urandom;
         do_push = iv && (model.size() < DEPTH);
         do_pop  = ordy && (model.size() > 0);
         drive(r, f, iv, ordy, ri, rx);
         if (r || f) begin
            model.delete();
         end else begin
            if (do_pop)  void'(model.pop_front());
            if (do_push) model.push_back({ri, rx});
         end
         if (model.size() > 0)
            check_all($sformatf("rnd%0d", n), 1'b1, model[0][63:32], model[0][31:0], model.size());
         else
            check_all($sformatf("rnd%0d", n), 1'b0, 32'h0, 32'h0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
